// File: rtl/rpn_exec_ctrl.sv
// rpn_exec_ctrl -- execution sequencer for the RPN calculator.
//
// Accepts number/operator tokens from the token decoder, keeps the operand
// stack, drives a shared multi-cycle ALU through a start/done handshake and
// hands answers to the transmitter through a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tok_valid/ready token handshake; tok_ready is high only while idle
//   tok_is_op       1 = operator (tok_op), 0 = number (tok_num)
//   tok_op          0 add, 1 sub, 2 mul, 3 emit
//   alu_start       one-cycle start pulse to the ALU
//   alu_op/a/b      operation and operands, held from start until done
//   alu_done        result strobe, alu_result sampled with it
//   ans_valid/data  answer to the transmitter, held until tx_ready
//   err_underflow   one-cycle pulse: too few operands for the token
//   err_overflow    one-cycle pulse: number pushed onto a full stack
//   depth           stack occupancy, 0..DEPTH
module rpn_exec_ctrl #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 8,
   parameter int DEPTH_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tok_valid,
   output logic               tok_ready,
   input  logic               tok_is_op,
   input  logic [1:0]         tok_op,
   input  logic [WIDTH-1:0]   tok_num,
   output logic               alu_start,
   output logic [1:0]         alu_op,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic               alu_done,
   input  logic [WIDTH-1:0]   alu_result,
   output logic               ans_valid,
   output logic [WIDTH-1:0]   ans_data,
   input  logic               tx_ready,
   output logic               err_underflow,
   output logic               err_overflow,
   output logic [DEPTH_W:0]   depth
);

   typedef enum logic [1:0] {IDLE, ALU_START, ALU_WAIT, EMIT} state_t;

   localparam logic [DEPTH_W:0] FULL = (DEPTH_W+1)'(DEPTH);
   localparam logic [DEPTH_W:0] ONE  = (DEPTH_W+1)'(1);
   localparam logic [DEPTH_W:0] TWO  = (DEPTH_W+1)'(2);

   state_t             state;
   logic [WIDTH-1:0]   stack [DEPTH];
   logic [DEPTH_W-1:0] top_idx;
   logic [DEPTH_W-1:0] sec_idx;
   logic               accept;
   logic               push_en;
   logic               wb_en;

   // Index arithmetic wraps in DEPTH_W bits; DEPTH is a power of two so a
   // full stack (depth == DEPTH) still addresses its top entry correctly.
   assign top_idx = depth[DEPTH_W-1:0] - DEPTH_W'(1);
   assign sec_idx = depth[DEPTH_W-1:0] - DEPTH_W'(2);
   assign accept  = tok_valid & tok_ready;
   assign push_en = accept & ~tok_is_op & (depth < FULL) & ~rst;
   // A result strobe only counts while waiting; reset discards it.
   assign wb_en   = (state == ALU_WAIT) & alu_done & ~rst;

   // Stack storage carries no reset; its contents are meaningless above depth.
   always_ff @(posedge clk) begin
      if (push_en)
         stack[depth[DEPTH_W-1:0]] <= tok_num;
      else if (wb_en)
         stack[sec_idx] <= alu_result;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         depth         <= '0;
         tok_ready     <= 1'b1;
         alu_start     <= 1'b0;
         alu_op        <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         ans_valid     <= 1'b0;
         ans_data      <= '0;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         alu_start     <= 1'b0;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!tok_is_op) begin
                     if (depth < FULL)
                        depth <= depth + ONE;
                     else
                        err_overflow <= 1'b1;
                  end else if (tok_op == 2'd3) begin
                     if (depth == '0) begin
                        err_underflow <= 1'b1;
                     end else begin
                        ans_data  <= stack[top_idx];
                        ans_valid <= 1'b1;
                        tok_ready <= 1'b0;
                        state     <= EMIT;
                     end
                  end else if (depth < TWO) begin
                     err_underflow <= 1'b1;
                  end else begin
                     // Left operand is second-from-top so sub gives a - b.
                     alu_a     <= stack[sec_idx];
                     alu_b     <= stack[top_idx];
                     alu_op    <= tok_op;
                     alu_start <= 1'b1;
                     tok_ready <= 1'b0;
                     state     <= ALU_START;
                  end
               end
            end
            ALU_START: begin
               state <= ALU_WAIT;
            end
            ALU_WAIT: begin
               if (alu_done) begin
                  depth     <= depth - ONE;
                  tok_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            EMIT: begin
               if (tx_ready) begin
                  depth     <= depth - ONE;
                  ans_valid <= 1'b0;
                  tok_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_exec_ctrl.sv
// Testbench for rpn_exec_ctrl: directed token table, hand-written corner
// sequences (back-to-back pushes, resets mid-operation) and a randomized
// token stream checked against a queue-based stack model. A behavioural ALU
// answers each start pulse after a programmable latency.
module tb_rpn_exec_ctrl;

   localparam int WIDTH   = 16;
   localparam int DEPTH   = 8;
   localparam int DEPTH_W = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               tok_valid;
   logic               tok_ready;
   logic               tok_is_op;
   logic [1:0]         tok_op;
   logic [WIDTH-1:0]   tok_num;
   logic               alu_start;
   logic [1:0]         alu_op;
   logic [WIDTH-1:0]   alu_a;
   logic [WIDTH-1:0]   alu_b;
   logic               alu_done;
   logic [WIDTH-1:0]   alu_result;
   logic               ans_valid;
   logic [WIDTH-1:0]   ans_data;
   logic               tx_ready;
   logic               err_underflow;
   logic               err_overflow;
   logic [DEPTH_W:0]   depth;

   int nvec  = 0;
   int nfail = 0;
   int alu_lat  = 2;
   bit stray_en = 1'b0;

   always #5 clk = ~clk;

   rpn_exec_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
      .clk(clk), .rst(rst),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
      .tok_op(tok_op), .tok_num(tok_num),
      .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_result(alu_result),
      .ans_valid(ans_valid), .ans_data(ans_data), .tx_ready(tx_ready),
      .err_underflow(err_underflow), .err_overflow(err_overflow),
      .depth(depth)
   );

   function automatic logic [WIDTH-1:0] alu_ref(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         2'd0:    r = a + b;
         2'd1:    r = a - b;
         default: r = a * b;
      endcase
      return r;
   endfunction

   // Behavioural ALU: result k cycles after the start cycle. With stray_en
   // it also raises a junk done during the start cycle itself.
   initial begin
      logic [WIDTH-1:0] ra, rb, rr;
      logic [1:0]       rop;
      int               waited;
      alu_done   = 1'b0;
      alu_result = '0;
      forever begin
         @(posedge clk); #2;
         if (alu_start) begin
            ra = alu_a; rb = alu_b; rop = alu_op;
            rr = alu_ref(rop, ra, rb);
            waited = 0;
            if (stray_en) begin
               alu_result = 16'hDEAD;
               alu_done   = 1'b1;
               @(posedge clk); #2;
               alu_done   = 1'b0;
               waited     = 1;
            end
            repeat (alu_lat - waited) @(posedge clk);
            #2;
            alu_result = rr;
            alu_done   = 1'b1;
            @(posedge clk); #2;
            alu_done   = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Presents one token, follows it to completion and checks the outcome.
   task automatic run_token(input bit is_op, input logic [1:0] op, input logic [WIDTH-1:0] num,
                            input int hold, input int lat, input bit stray, input int exp_depth,
                            input bit exp_unf, input bit exp_ovf, input logic [WIDTH-1:0] exp_a,
                            input logic [WIDTH-1:0] exp_b, input logic [WIDTH-1:0] exp_ans);
      int n;
      bit ok;
      alu_lat  = lat;
      stray_en = stray;
      tx_ready = (is_op && op == 2'd3) ? 1'b0 : 1'($urandom_range(0, 1));
      check("tok_ready_idle", tok_ready, 1);
      tok_valid = 1'b1; tok_is_op = is_op; tok_op = op; tok_num = num;
      step();
      tok_valid = 1'b0;
      tok_num   = WIDTH'($urandom);
      check("err_underflow", err_underflow, exp_unf);
      check("err_overflow", err_overflow, exp_ovf);
      if (exp_unf || exp_ovf) begin
         check("no_alu_start", alu_start, 0);
         check("no_ans_valid", ans_valid, 0);
         step();
         check("err_one_cycle", {err_underflow, err_overflow}, 0);
      end else if (is_op && op != 2'd3) begin
         check("alu_start", alu_start, 1);
         check("alu_a", alu_a, exp_a);
         check("alu_b", alu_b, exp_b);
         check("alu_op", alu_op, op);
         n = 0; ok = 1'b1;
         while (!tok_ready && n < 100) begin
            step();
            n++;
            if (alu_start !== 1'b0 || alu_a !== exp_a || alu_b !== exp_b || alu_op !== op)
               ok = 1'b0;
         end
         check("alu_latency", n, lat + 1);
         check("alu_hold", ok, 1);
      end else if (is_op) begin
         check("ans_valid", ans_valid, 1);
         check("ans_data", ans_data, exp_ans);
         check("tok_ready_busy", tok_ready, 0);
         ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            step();
            if (ans_valid !== 1'b1 || ans_data !== exp_ans || tok_ready !== 1'b0) ok = 1'b0;
         end
         check("ans_hold", ok, 1);
         tx_ready = 1'b1;
         step();
         tx_ready = 1'b0;
         check("ans_release", ans_valid, 0);
      end
      check("depth", depth, exp_depth);
   endtask

   typedef struct {
      bit               is_op;
      logic [1:0]       op;
      logic [WIDTH-1:0] num;
      int               hold;
      int               lat;
      bit               stray;
      int               exp_depth;
      bit               exp_unf;
      bit               exp_ovf;
      logic [WIDTH-1:0] exp_a;
      logic [WIDTH-1:0] exp_b;
      logic [WIDTH-1:0] exp_ans;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic [WIDTH-1:0] q[$];
      logic [WIDTH-1:0] a, b, r, ans;
      bit               ok, unf, ovf, is_op;
      logic [1:0]       op;
      int               sel;

      //            is_op op    num       hold lat stray dep unf  ovf  a         b       ans
      tbl[0]  = '{1'b0, 2'd0, 16'd3,      0,   1,  1'b0, 1,  1'b0, 1'b0, 16'd0,    16'd0,  16'd0};
      tbl[1]  = '{1'b0, 2'd0, 16'd4,      0,   1,  1'b0, 2,  1'b0, 1'b0, 16'd0,    16'd0,  16'd0};
      tbl[2]  = '{1'b1, 2'd0, 16'd0,      0,   2,  1'b0, 1,  1'b0, 1'b0, 16'd3,    16'd4,  16'd0};
      tbl[3]  = '{1'b1, 2'd3, 16'd0,      5,   1,  1'b0, 0,  1'b0, 1'b0, 16'd0,    16'd0,  16'd7};
      tbl[4]  = '{1'b0, 2'd0, 16'd10,     0,   1,  1'b0, 1,  1'b0, 1'b0, 16'd0,    16'd0,  16'd0};
      tbl[5]  = '{1'b0, 2'd0, 16'd3,      0,   1,  1'b0, 2,  1'b0, 1'b0, 16'd0,    16'd0,  16'd0};
      tbl[6]  = '{1'b1, 2'd1, 16'd0,      0,   3,  1'b0, 1,  1'b0, 1'b0, 16'd10,   16'd3,  16'd0};
      tbl[7]  = '{1'b1, 2'd3, 16'd0,      0,   1,  1'b0, 0,  1'b0, 1'b0, 16'd0,    16'd0,  16'd7};
      tbl[8]  = '{1'b1, 2'd2, 16'd0,      0,   1,  1'b0, 0,  1'b1, 1'b0, 16'd0,    16'd0,  16'd0};
      tbl[9]  = '{1'b1, 2'd3, 16'd0,      0,   1,  1'b0, 0,  1'b1, 1'b0, 16'd0,    16'd0,  16'd0};
      tbl[10] = '{1'b0, 2'd0, 16'hFFFF,   0,   1,  1'b0, 1,  1'b0, 1'b0, 16'd0,    16'd0,  16'd0};
      tbl[11] = '{1'b0, 2'd0, 16'd2,      0,   1,  1'b0, 2,  1'b0, 1'b0, 16'd0,    16'd0,  16'd0};
      tbl[12] = '{1'b1, 2'd0, 16'd0,      0,   3,  1'b1, 1,  1'b0, 1'b0, 16'hFFFF, 16'd2,  16'd0};
      tbl[13] = '{1'b1, 2'd3, 16'd0,      2,   1,  1'b0, 0,  1'b0, 1'b0, 16'd0,    16'd0,  16'd1};

      tok_valid = 1'b0; tok_is_op = 1'b0; tok_op = '0; tok_num = '0; tx_ready = 1'b0;
      do_reset();

      // Reset state
      check("rst_depth", depth, 0);
      check("rst_tok_ready", tok_ready, 1);
      check("rst_ctrl", {alu_start, ans_valid, err_underflow, err_overflow}, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_ans_data", ans_data, 0);

      // Directed token table
      foreach (tbl[i])
         run_token(tbl[i].is_op, tbl[i].op, tbl[i].num, tbl[i].hold, tbl[i].lat, tbl[i].stray,
                   tbl[i].exp_depth, tbl[i].exp_unf, tbl[i].exp_ovf, tbl[i].exp_a,
                   tbl[i].exp_b, tbl[i].exp_ans);

      // tok_valid held for nine numbers: eight land on consecutive cycles
      do_reset();
      tok_valid = 1'b1; tok_is_op = 1'b0;
      ok = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tok_num = WIDTH'(i);
         if (tok_ready !== 1'b1 || int'(depth) != (i > 8 ? 8 : i - 1) || err_overflow !== 1'b0)
            ok = 1'b0;
         step();
      end
      tok_valid = 1'b0;
      check("burst_push", ok, 1);
      check("burst_depth", depth, 8);
      check("burst_overflow", err_overflow, 1);
      step();
      check("burst_ovf_clear", err_overflow, 0);
      run_token(1'b1, 2'd3, '0, 1, 1, 1'b0, 7, 1'b0, 1'b0, '0, '0, 16'd8);

      // Reset while the ALU is busy; its late result must be dropped
      do_reset();
      run_token(1'b0, 2'd0, 16'd5, 0, 1, 1'b0, 1, 1'b0, 1'b0, '0, '0, '0);
      run_token(1'b0, 2'd0, 16'd6, 0, 1, 1'b0, 2, 1'b0, 1'b0, '0, '0, '0);
      alu_lat = 4; stray_en = 1'b0;
      tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = 2'd2;
      step();
      tok_valid = 1'b0;
      check("rw_alu_start", alu_start, 1);
      check("rw_alu_a", alu_a, 5);
      check("rw_alu_b", alu_b, 6);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (depth !== '0 || tok_ready !== 1'b1 || err_underflow !== 1'b0 ||
             err_overflow !== 1'b0 || alu_start !== 1'b0)
            ok = 1'b0;
         step();
      end
      check("rw_quiet_after_rst", ok, 1);
      check("rw_alu_a_cleared", alu_a, 0);
      run_token(1'b0, 2'd0, 16'd9, 0, 1, 1'b0, 1, 1'b0, 1'b0, '0, '0, '0);
      run_token(1'b1, 2'd3, '0, 0, 1, 1'b0, 0, 1'b0, 1'b0, '0, '0, 16'd9);

      // Reset while an answer is held: withdrawn without a handshake
      run_token(1'b0, 2'd0, 16'h55, 0, 1, 1'b0, 1, 1'b0, 1'b0, '0, '0, '0);
      tx_ready = 1'b0;
      tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = 2'd3;
      step();
      tok_valid = 1'b0;
      check("re_ans_valid", ans_valid, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("re_ans_withdrawn", ans_valid, 0);
      check("re_ans_data", ans_data, 0);
      check("re_depth", depth, 0);
      check("re_tok_ready", tok_ready, 1);

      // Randomized token stream against the stack model
      do_reset();
      q.delete();
      for (int t = 0; t < 300; t++) begin
         sel = $urandom_range(0, 9);
         is_op = (sel >= 5);
         op  = (sel >= 8) ? 2'd3 : 2'($urandom_range(0, 2));
         a   = '0; b = '0; ans = '0; unf = 1'b0; ovf = 1'b0;
         r   = WIDTH'($urandom);
         if (!is_op) begin
            if (q.size() < DEPTH) q.push_back(r);
            else ovf = 1'b1;
         end else if (op == 2'd3) begin
            if (q.size() == 0) unf = 1'b1;
            else ans = q.pop_back();
         end else begin
            if (q.size() < 2) unf = 1'b1;
            else begin
               b = q.pop_back();
               a = q.pop_back();
               q.push_back(alu_ref(op, a, b));
            end
         end
         alu_lat = $urandom_range(1, 4);
         run_token(is_op, op, r, $urandom_range(0, 3), alu_lat,
                   (alu_lat >= 2) ? 1'($urandom_range(0, 1)) : 1'b0,
                   q.size(), unf, ovf, a, b, ans);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/rpn_exec_ctrl.md
Name: rpn_exec_ctrl

Overview:
- Execution sequencer for the RPN calculator. Sits between the token decoder (UART RX side) and the answer transmitter (UART TX side).
- Owns the operand stack. Sequences a shared multi-cycle ALU through a start/done handshake.
- Pushes numbers, pops operands for operators, writes back ALU results, and emits answers with a valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width in bits.
- DEPTH, 8, stack entries; must be a power of 2.
- DEPTH_W, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tok_valid  in  1  token present.
- tok_ready  out  1  controller can accept a token this cycle.
- tok_is_op  in  1  1 = operator, 0 = number.
- tok_op  in  2  0 add, 1 sub, 2 mul, 3 emit ('=').
- tok_num  in  WIDTH  number value, used when tok_is_op = 0.
- alu_start  out  1  one-cycle start pulse.
- alu_op  out  2  operation code, held stable from start until done.
- alu_a  out  WIDTH  left operand (second-from-top), held.
- alu_b  out  WIDTH  right operand (top), held.
- alu_done  in  1  result valid pulse.
- alu_result  in  WIDTH  ALU result, sampled when alu_done = 1.
- ans_valid  out  1  answer available.
- ans_data  out  WIDTH  answer value.
- tx_ready  in  1  transmitter accepts the answer.
- err_underflow  out  1  one-cycle pulse.
- err_overflow  out  1  one-cycle pulse.
- depth  out  DEPTH_W+1  current stack occupancy, range 0..DEPTH.

Behaviour:
- Reset values:
  - state = IDLE, depth = 0, tok_ready = 1.
  - alu_start, ans_valid, err_underflow, err_overflow = 0.
  - alu_op, alu_a, alu_b, ans_data = 0.
  - Stack contents don't-care.
- A token is accepted when tok_valid & tok_ready. tok_ready = 1 only in IDLE.
- FSM states: IDLE, ALU_START, ALU_WAIT, EMIT.
- IDLE, number token:
  - If depth < DEPTH: write tok_num at index depth; depth+1 visible next cycle. Stay in IDLE, so back-to-back pushes run at 1 token/cycle.
  - If depth == DEPTH: token dropped, err_overflow pulses next cycle, stack unchanged.
- IDLE, binary op (0/1/2):
  - If depth < 2: dropped, err_underflow pulses next cycle, stack unchanged.
  - Else: latch alu_a = stack[depth-2], alu_b = stack[depth-1], alu_op = tok_op, then go to ALU_START.
  - Operand order is fixed: sub computes alu_a - alu_b.
- ALU_START: alu_start = 1 for exactly this cycle, then go to ALU_WAIT.
- ALU_WAIT:
  - alu_done is sampled only in this state; it is ignored in all other states, including a stray done during ALU_START.
  - On alu_done: stack[depth-2] <= alu_result, depth <= depth-1, go to IDLE.
  - Result is truncated to WIDTH bits; no overflow flag for arithmetic.
  - No timeout: the controller waits indefinitely.
- Latency, binary op with ALU done at k cycles after start:
  - Token accepted at edge T; alu_start high in cycle T+1; alu_done in cycle T+1+k.
  - depth updated and tok_ready = 1 in cycle T+2+k.
- IDLE, emit (op 3):
  - If depth == 0: underflow pulse, no answer.
  - Else: ans_data <= stack[depth-1], ans_valid = 1 next cycle, go to EMIT.
- EMIT:
  - ans_valid and ans_data are held stable until tx_ready = 1.
  - On the handshake cycle: depth-1, then ans_valid = 0 and IDLE next cycle.
  - tx_ready while ans_valid = 0 is ignored.
- Error pulses are mutually exclusive and last exactly one cycle per rejected token.
- Reset in any state, including mid-ALU_WAIT or mid-EMIT, returns all outputs to reset values on the next edge.
  - A pending ALU result arriving after reset is discarded.
  - A held answer is withdrawn with no handshake.
- Only one operation is in flight at a time; no token is accepted during ALU_START, ALU_WAIT or EMIT.

Test Plan:
- Push 3, push 4, op add; ALU model done 2 cycles after start -> alu_a = 3, alu_b = 4, alu_start high exactly 1 cycle; then depth = 1. Emit with tx_ready low 5 cycles, then high -> ans_valid held 6 cycles with ans_data = 7; depth = 0 after the handshake.
- Push 10, push 3, op sub -> alu_a = 10, alu_b = 3, alu_op = 1. Result 7 written; emit returns 7.
- Empty stack, op mul -> err_underflow pulses one cycle, alu_start never asserts, depth stays 0. Emit on empty stack -> err_underflow again, ans_valid stays 0.
- tok_valid held high for 9 number tokens (1..9), DEPTH = 8 -> 8 accepted on consecutive cycles, depth = 8; 9th gives err_overflow. Emit returns 8.
- Push 5, push 6, op mul; assert rst in ALU_WAIT, then drive alu_done 2 cycles after reset -> depth = 0, tok_ready = 1, no stack write, no error pulse.
- Push 0xFFFF, push 2, op add with WIDTH = 16 -> the ALU model's truncated result 0x0001 is stored, no error flags; alu_done asserted in ALU_START is ignored.
